bcd_sum_display: RTL and testbench

//  Downstream consumer of the 1-digit BCD adder. Latches operands A, B and the adder's

---
 rtl/bcd_sum_display.sv | 119 +++++++++++
 tb/tb_bcd_sum_display.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sum_display.sv
// rtl/bcd_sum_display.sv - latched BCD adder operands/result on a 4-digit multiplexed 7-segment display
module bcd_sum_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       c,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       bcd_err
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [3:0]    s_q, s_d;
    logic          c_q, c_d;
    logic          err_q, err_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          wrap;
    logic [3:0]    digit;
    logic          blank;

    // Active-low encoding; anything above 9 renders as 'E'.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h06;
        endcase
        return p;
    endfunction

    // Prescaler, scan index and operand latch next-state.
    always_comb begin
        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        err_d   = err_q;
        if (load) begin
            a_d   = a;
            b_d   = b;
            s_d   = s;
            c_d   = c;
            // Flag is judged on the incoming values so it tracks the latch edge.
            err_d = (a > 4'd9) || (b > 4'd9) || (s > 4'd9);
        end
    end

    // Digit selection for the current scan slot; anode and pattern derive from the same index.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd0:    digit = s_q;
            2'd1:    begin
                         digit = {3'b000, c_q};
                         blank = BLANK_LZ && !c_q;
                     end
            2'd2:    digit = b_q;
            default: digit = a_q;
        endcase
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : encode(digit);
    end

    // All state, with outputs registered together so anode and pattern switch on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            s_q     <= 4'd0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'hF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            err_q   <= err_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign bcd_err = err_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// tb/tb_bcd_sum_display.sv - randomized self-checking bench for bcd_sum_display
module tb_bcd_sum_display;

    localparam int DIV = 4;
    localparam logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] a = 4'd0, b = 4'd0, s = 4'd0;
    logic       c = 1'b0;
    logic [6:0] seg1, seg0;
    logic [3:0] an1, an0;
    logic       err1, err0;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: edges since reset and the latched operands.
    int         m_cyc;
    logic [3:0] m_a, m_b, m_s;
    logic       m_c;
    logic [3:0] exp_an;
    logic [6:0] exp_seg1, exp_seg0;
    logic       exp_err;

    always #5 clk = ~clk;

    bcd_sum_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .load(load), .a(a), .b(b), .s(s), .c(c),
        .seg(seg1), .an(an1), .bcd_err(err1)
    );

    bcd_sum_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .load(load), .a(a), .b(b), .s(s), .c(c),
        .seg(seg0), .an(an0), .bcd_err(err0)
    );

    // Digit slot k lit during edges-since-reset window [k*DIV, (k+1)*DIV) modulo 4 slots.
    function automatic int slot_of(input int cyc);
        return (cyc / DIV) % 4;
    endfunction

    function automatic logic [6:0] model_seg(input int cyc, input bit blz,
                                             input logic [3:0] va, input logic [3:0] vb,
                                             input logic [3:0] vs, input logic vc);
        logic [3:0] digits [4];
        int k;
        digits[0] = vs;
        digits[1] = {3'b000, vc};
        digits[2] = vb;
        digits[3] = va;
        k = slot_of(cyc);
        if (k == 1 && blz && !vc) return 7'h7F;
        return ENC[digits[k]];
    endfunction

    // Display shows what was selected one edge earlier; bcd_err follows the load edge directly.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc    <= 0;
            m_a      <= 4'd0;
            m_b      <= 4'd0;
            m_s      <= 4'd0;
            m_c      <= 1'b0;
            exp_an   <= 4'hF;
            exp_seg1 <= 7'h7F;
            exp_seg0 <= 7'h7F;
            exp_err  <= 1'b0;
        end else begin
            exp_an   <= ~(4'b0001 << slot_of(m_cyc));
            exp_seg1 <= model_seg(m_cyc, 1'b1, m_a, m_b, m_s, m_c);
            exp_seg0 <= model_seg(m_cyc, 1'b0, m_a, m_b, m_s, m_c);
            if (load) begin
                m_a     <= a;
                m_b     <= b;
                m_s     <= s;
                m_c     <= c;
                exp_err <= (a > 9) || (b > 9) || (s > 9);
            end
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        #7 rst = 1'b0;
        @(negedge clk);
        load = 1'b1; a = 4'd12; b = 4'd3; s = 4'd4; c = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (seg1 !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got=%h want=7f", seg1); end
        n_vec++; if (an1 !== 4'hF) begin n_bad++; $display("FAIL reset_an got=%h want=f", an1); end
        n_vec++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err1); end
        n_vec++; if (seg0 !== 7'h7F) begin n_bad++; $display("FAIL reset_seg_nb got=%h want=7f", seg0); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (an1 !== 4'hE) begin n_bad++; $display("FAIL post_reset_an got=%h want=e", an1); end
        n_vec++; if (seg1 !== 7'h40) begin n_bad++; $display("FAIL post_reset_seg got=%h want=40", seg1); end
        n_vec++; if (seg0 !== 7'h40) begin n_bad++; $display("FAIL post_reset_seg_nb got=%h want=40", seg0); end
    endtask

    task automatic test_scan_pairs();
        logic [6:0] want;
        load = 1'b1; a = 4'd7; b = 4'd5; s = 4'd2; c = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4 * DIV; i++) begin
            case (an1)
                4'hE:    want = 7'h24;
                4'hD:    want = 7'h79;
                4'hB:    want = 7'h12;
                4'h7:    want = 7'h78;
                default: want = 7'h7F;
            endcase
            n_vec++; if (seg1 !== want) begin n_bad++; $display("FAIL scan_pair an=%h seg got=%h want=%h", an1, seg1, want); end
            n_vec++; if (an1 !== exp_an) begin n_bad++; $display("FAIL scan_an got=%h want=%h", an1, exp_an); end
            n_vec++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL scan_err got=%b want=0", err1); end
            @(negedge clk);
        end
    endtask

    task automatic test_blanking();
        int seen = 0;
        load = 1'b1; a = 4'd3; b = 4'd4; s = 4'd7; c = 1'b0;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4 * DIV; i++) begin
            if (an1 == 4'hD) begin
                seen++;
                n_vec++; if (seg1 !== 7'h7F) begin n_bad++; $display("FAIL blank_tens got=%h want=7f", seg1); end
                n_vec++; if (seg0 !== 7'h40) begin n_bad++; $display("FAIL noblank_tens got=%h want=40", seg0); end
            end
            n_vec++; if (an0 !== an1) begin n_bad++; $display("FAIL blank_an_nb got=%h want=%h", an0, an1); end
            @(negedge clk);
        end
        n_vec++; if (seen != DIV) begin n_bad++; $display("FAIL blank_tens_slot got=%0d want=%0d", seen, DIV); end
    endtask

    task automatic test_bcd_err();
        int seen = 0;
        load = 1'b1; a = 4'd12; b = 4'd1; s = 4'd9; c = 1'b0;
        @(negedge clk);
        load = 1'b0;
        n_vec++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b want=1", err1); end
        @(negedge clk);
        for (int i = 0; i < 4 * DIV; i++) begin
            if (an1 == 4'h7) begin
                seen++;
                n_vec++; if (seg1 !== 7'h06) begin n_bad++; $display("FAIL err_a_slot got=%h want=06", seg1); end
            end
            n_vec++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL err_hold got=%b want=1", err1); end
            @(negedge clk);
        end
        n_vec++; if (seen != DIV) begin n_bad++; $display("FAIL err_a_seen got=%0d want=%0d", seen, DIV); end
        load = 1'b1; a = 4'd2; b = 4'd1; s = 4'd3; c = 1'b0;
        @(negedge clk);
        load = 1'b0;
        n_vec++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b want=0", err1); end
    endtask

    task automatic test_load_on_wrap();
        logic [3:0] vals [4];
        int  tries = 0;
        int  nidx;
        while ((m_cyc % DIV) != DIV - 1 && tries < 2 * DIV) begin
            @(negedge clk);
            tries++;
        end
        n_vec++;
        if ((m_cyc % DIV) != DIV - 1) begin
            n_bad++; $display("FAIL wrap_timeout got=%0d want=%0d", m_cyc % DIV, DIV - 1);
        end else begin
            vals[0] = 4'd6; vals[1] = 4'd1; vals[2] = 4'd8; vals[3] = 4'd9;
            nidx = (m_cyc / DIV + 1) % 4;
            load = 1'b1; a = vals[3]; b = vals[2]; s = vals[0]; c = 1'b1;
            @(negedge clk);
            load = 1'b0;
            n_vec++; if (seg1 !== exp_seg1) begin n_bad++; $display("FAIL wrap_prev_seg got=%h want=%h", seg1, exp_seg1); end
            @(negedge clk);
            n_vec++; if (an1 !== ~(4'b0001 << nidx)) begin n_bad++; $display("FAIL wrap_an got=%h want=%h", an1, ~(4'b0001 << nidx)); end
            n_vec++; if (seg1 !== ENC[vals[nidx]]) begin n_bad++; $display("FAIL wrap_seg got=%h want=%h", seg1, ENC[vals[nidx]]); end
        end
    endtask

    task automatic test_free_run();
        logic [3:0] prev;
        int run = 0;
        bit started = 1'b0;
        load = 1'b0;
        prev = an1;
        for (int i = 0; i < 14 * DIV; i++) begin
            @(negedge clk);
            n_vec++; if (!$onehot(~an1)) begin n_bad++; $display("FAIL onehot got=%h", an1); end
            if (an1 != prev) begin
                n_vec++; if (an1 !== {prev[2:0], prev[3]}) begin n_bad++; $display("FAIL an_order got=%h want=%h", an1, {prev[2:0], prev[3]}); end
                if (started) begin
                    n_vec++; if (run != DIV) begin n_bad++; $display("FAIL dwell got=%0d want=%0d", run, DIV); end
                end
                started = 1'b1;
                run = 1;
                prev = an1;
            end else begin
                run++;
            end
            n_vec++; if (seg1 !== exp_seg1) begin n_bad++; $display("FAIL free_seg got=%h want=%h", seg1, exp_seg1); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_vec++; if (an1 !== exp_an) begin n_bad++; $display("FAIL rnd_an got=%h want=%h", an1, exp_an); end
            n_vec++; if (seg1 !== exp_seg1) begin n_bad++; $display("FAIL rnd_seg got=%h want=%h", seg1, exp_seg1); end
            n_vec++; if (seg0 !== exp_seg0) begin n_bad++; $display("FAIL rnd_seg_nb got=%h want=%h", seg0, exp_seg0); end
            n_vec++; if (err1 !== exp_err) begin n_bad++; $display("FAIL rnd_err got=%b want=%b", err1, exp_err); end
            n_vec++; if (err0 !== exp_err) begin n_bad++; $display("FAIL rnd_err_nb got=%b want=%b", err0, exp_err); end
            n_vec++; if (an0 !== exp_an) begin n_bad++; $display("FAIL rnd_an_nb got=%h want=%h", an0, exp_an); end
            load = ($urandom_range(0, 3) == 0) || (i >= 250 && i < 262);
            a    = 4'($urandom_range(0, 15));
            b    = 4'($urandom_range(0, 11));
            s    = 4'($urandom_range(0, 10));
            c    = 1'($urandom_range(0, 1));
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_pairs();
        test_blanking();
        test_bcd_err();
        test_load_on_wrap();
        test_free_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
